// File: rtl/mem_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_seq_pkg
//  Description : Shared definitions for the byte-wide memory sequencer.
//                Holds the sequencer state enum, the data_width code points,
//                the beat-count function and the alignment test.
//  Options     : MEM_SEQ_ALIGN_CHECK_EN (is_misaligned is only used when
//                this macro is defined)
//  Revision    : 1.0  initial release
// ============================================================================
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // data_width code points; any code not listed here behaves as a word
    localparam logic [2:0] c_DW_WORD   = 3'b000;
    localparam logic [2:0] c_DW_HALF_S = 3'b001;
    localparam logic [2:0] c_DW_BYTE_S = 3'b010;
    localparam logic [2:0] c_DW_HALF_U = 3'b101;
    localparam logic [2:0] c_DW_BYTE_U = 3'b110;

    // Number of one-byte memory beats needed for an access of width dw.
    function automatic logic [2:0] beat_count(input logic [2:0] dw);
        case (dw)
            c_DW_HALF_S, c_DW_HALF_U: beat_count = 3'd2;
            c_DW_BYTE_S, c_DW_BYTE_U: beat_count = 3'd1;
            default:                  beat_count = 3'd4;
        endcase
    endfunction

    // Halves must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [2:0] dw,
                                           input logic [1:0] addr_lo);
        case (beat_count(dw))
            3'd2:    is_misaligned = addr_lo[0];
            3'd4:    is_misaligned = (addr_lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_seq_if
//  Description : Pipeline-side request/response bus of the memory sequencer.
//                master = pipeline (issues requests), slave = mem_seq.
//  Signals     : req_valid, req_write, data_width[2:0], addr[31:0],
//                wdata[31:0]                          (master -> slave)
//                stall, rdata[31:0], rdata_valid,
//                misaligned                           (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_seq_if;

    logic        req_valid;
    logic        req_write;
    logic [2:0]  data_width;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misaligned;

    modport master (
        output req_valid, req_write, data_width, addr, wdata,
        input  stall, rdata, rdata_valid, misaligned
    );

    modport slave (
        input  req_valid, req_write, data_width, addr, wdata,
        output stall, rdata, rdata_valid, misaligned
    );

endinterface
`default_nettype wire

// File: rtl/load_ext.sv
`default_nettype none
// ============================================================================
//  Module      : load_ext
//  Description : Combinational sign/zero extender for assembled load data.
//  Ports       : i_data_width[2:0]  width code of the load
//                i_raw[31:0]        little-endian assembled bytes
//                o_ext[31:0]        extended result
//  Revision    : 1.0  initial release
// ============================================================================
module load_ext
    import mem_seq_pkg::*;
(
    input  wire logic [2:0]  i_data_width,
    input  wire logic [31:0] i_raw,
    output logic      [31:0] o_ext
);

    always_comb begin
        o_ext = i_raw;
        case (i_data_width)
            c_DW_HALF_S: o_ext = {{16{i_raw[15]}}, i_raw[15:0]};
            c_DW_HALF_U: o_ext = {16'h0000, i_raw[15:0]};
            c_DW_BYTE_S: o_ext = {{24{i_raw[7]}}, i_raw[7:0]};
            c_DW_BYTE_U: o_ext = {24'h000000, i_raw[7:0]};
            c_DW_WORD:   o_ext = i_raw;
            default:     o_ext = i_raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mem_seq
//  Description : Sequences byte/half/word loads and stores onto a single-
//                ported, byte-wide, synchronous-read memory, one byte per
//                cycle. Loads are assembled little-endian and extended.
//  Ports       : clk, rst            clock, asynchronous active-high reset
//                bus (slave)         request/response bus (mem_seq_if)
//                mem_en, mem_we      byte-memory enable / write enable
//                mem_addr[31:0]      byte-memory address
//                mem_wdata[7:0]      byte-memory write data
//                mem_rdata[7:0]      byte-memory read data (1-cycle latency)
//  Options     : MEM_SEQ_ALIGN_CHECK_EN - reject misaligned halves/words in
//                one cycle with a misaligned pulse instead of running beats
//  Revision    : 1.0  initial release
// ============================================================================
module mem_seq
    import mem_seq_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    mem_seq_if.slave         bus,
    output logic             mem_en,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    input  wire logic [7:0]  mem_rdata
);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_write;
    logic [2:0]  r_width;
    logic [31:0] r_asm;
    logic [31:0] r_rdata;
    logic        r_rdata_valid;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
    logic        r_misaligned;
`endif

    logic [2:0]  w_beats;
    logic        w_last_beat;
    logic        w_capture;
    logic [1:0]  w_lane;
    logic        w_accept_misaligned;
    logic [31:0] w_asm;
    logic [31:0] w_ext;

    assign w_beats     = beat_count(r_width);
    assign w_last_beat = (r_cnt == (w_beats - 3'd1));

    // Read data trails its beat by one cycle, so the byte on mem_rdata
    // belongs to lane cnt-1 whenever at least one read beat has been issued.
    // In DRAIN cnt equals N, which lands on the final lane.
    assign w_capture = ((r_state == BUSY) && (r_cnt != 3'd0)) || (r_state == DRAIN);
    assign w_lane    = r_cnt[1:0] - 2'd1;

    always_comb begin
        w_asm = r_asm;
        if (w_capture) begin
            w_asm[{w_lane, 3'b000} +: 8] = mem_rdata;
        end
    end

    // Extension runs on the merged value so DRAIN can commit the final
    // result, including the last byte, straight into rdata.
    load_ext u_load_ext (
        .i_data_width (r_width),
        .i_raw        (w_asm),
        .o_ext        (w_ext)
    );

`ifdef MEM_SEQ_ALIGN_CHECK_EN
    assign w_accept_misaligned = is_misaligned(bus.data_width, bus.addr[1:0]);
`else
    assign w_accept_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= 3'd0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_write       <= 1'b0;
            r_width       <= 3'd0;
            r_asm         <= 32'd0;
            r_rdata       <= 32'd0;
            r_rdata_valid <= 1'b0;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
            r_misaligned  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_rdata_valid <= 1'b0;
                    if (bus.req_valid) begin
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_write <= bus.req_write;
                        r_width <= bus.data_width;
                        r_cnt   <= 3'd0;
                        r_asm   <= 32'd0;
                        if (w_accept_misaligned) begin
                            // rejected access: no beats, rdata untouched
                            r_state       <= DONE;
                            r_rdata_valid <= 1'b1;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
                            r_misaligned  <= 1'b1;
`endif
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (w_capture) begin
                        r_asm <= w_asm;
                    end
                    if (w_last_beat) begin
                        if (r_write) begin
                            r_state       <= DONE;
                            r_rdata_valid <= 1'b1;
                        end else begin
                            r_state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    r_rdata       <= w_ext;
                    r_rdata_valid <= 1'b1;
                    r_state       <= DONE;
                end

                DONE: begin
                    r_rdata_valid <= 1'b0;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
                    r_misaligned  <= 1'b0;
`endif
                    r_state       <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Memory side is a pure decode of the registered state, so reset
    // silences it in the same instant it is asserted.
    assign mem_en    = (r_state == BUSY);
    assign mem_we    = mem_en & r_write;
    assign mem_addr  = mem_en ? (r_addr + {29'd0, r_cnt}) : 32'd0;
    assign mem_wdata = mem_en ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'd0;

    // The accept cycle already stalls, so the pipeline never advances past
    // an instruction whose access has not completed.
    assign bus.stall = ~rst & (((r_state == IDLE) & bus.req_valid) |
                               (r_state == BUSY) | (r_state == DRAIN));
    assign bus.rdata       = r_rdata;
    assign bus.rdata_valid = r_rdata_valid;
`ifdef MEM_SEQ_ALIGN_CHECK_EN
    assign bus.misaligned  = r_misaligned;
`else
    assign bus.misaligned  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_seq
//  Description : Self-checking bench for mem_seq. A transaction-level model
//                expands each request into the expected cycle-by-cycle
//                outputs; a compare process checks them every cycle.
//  Options     : MEM_SEQ_ALIGN_CHECK_EN (expectations follow the same macro)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_seq;
    import mem_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    mem_seq_if bus ();

    mem_seq u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall;
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wd;
        logic        rv;
        logic        mis;
        logic        chk_rd;
        logic [31:0] rd;
    } rec_t;

    rec_t        exp_q[$];
    logic [7:0]  env_mem [0:4095];   // memory the DUT talks to
    logic [7:0]  ref_mem [0:4095];   // model's view of memory contents
    int          total = 0;
    int          bad   = 0;
    logic        started = 1'b0;
    int          stall_cnt = 0;
    int          en_cnt    = 0;
    logic [31:0] m_rdata = 32'd0;

    // Synchronous-read byte memory, 4 KiB window (address bits 11:0).
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr[11:0]] <= mem_wdata;
            else        mem_rdata <= env_mem[mem_addr[11:0]];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        rec_t e;
        if (started) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = '0;
                e.chk_rd = 1'b1;
                e.rd     = m_rdata;
            end
            check("stall",       {31'd0, bus.stall},       {31'd0, e.stall});
            check("mem_en",      {31'd0, mem_en},          {31'd0, e.en});
            check("mem_we",      {31'd0, mem_we},          {31'd0, e.we});
            check("mem_addr",    mem_addr,                 e.addr);
            check("mem_wdata",   {24'd0, mem_wdata},       {24'd0, e.wd});
            check("rdata_valid", {31'd0, bus.rdata_valid}, {31'd0, e.rv});
            check("misaligned",  {31'd0, bus.misaligned},  {31'd0, e.mis});
            if (e.chk_rd) check("rdata", bus.rdata, e.rd);
            if (bus.stall) stall_cnt++;
            if (mem_en)    en_cnt++;
        end
    end

    function automatic int nbytes(input logic [2:0] w);
        case (w)
            3'b001, 3'b101: return 2;
            3'b010, 3'b110: return 1;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] w, input logic [31:0] raw);
        case (w)
            3'b001:  return {{16{raw[15]}}, raw[15:0]};
            3'b101:  return {16'h0000, raw[15:0]};
            3'b010:  return {{24{raw[7]}}, raw[7:0]};
            3'b110:  return {24'h000000, raw[7:0]};
            default: return raw;
        endcase
    endfunction

    function automatic logic misal(input logic [2:0] w, input logic [31:0] a);
`ifdef MEM_SEQ_ALIGN_CHECK_EN
        int n;
        n = nbytes(w);
        return ((n == 2) && a[0]) || ((n == 4) && (a[1:0] != 2'b00));
`else
        return (a == 32'hFFFF_FFFF) && (w == 3'b111) && 1'b0;
`endif
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        env_mem[a[11:0]] <= v;
        ref_mem[a[11:0]]  = v;
    endtask

    // Issue one request in the current cycle and run it to completion.
    // abort >= 0 asserts rst in that cycle of the transaction (0 = accept).
    task automatic issue(input logic wr, input logic [2:0] w, input logic [31:0] a,
                         input logic [31:0] wd, input logic hold, input int abort);
        rec_t        r;
        rec_t        recs[$];
        int          n;
        logic [31:0] raw;
        logic [31:0] ba;
        n   = nbytes(w);
        raw = 32'd0;
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.data_width = w;
        bus.addr       = a;
        bus.wdata      = wd;
        r = '0; r.stall = 1'b1; r.chk_rd = 1'b1; r.rd = m_rdata;
        recs.push_back(r);
        if (misal(w, a)) begin
            r = '0; r.rv = 1'b1; r.mis = 1'b1; r.chk_rd = 1'b1; r.rd = m_rdata;
            recs.push_back(r);
        end else begin
            for (int k = 0; k < n; k++) begin
                ba = a + 32'(k);
                r = '0; r.stall = 1'b1; r.en = 1'b1; r.we = wr; r.addr = ba;
                r.wd = wd[8*k +: 8];
                recs.push_back(r);
                if (wr) begin
                    if ((abort < 0) || (k + 1 < abort)) ref_mem[ba[11:0]] = wd[8*k +: 8];
                end else begin
                    raw[8*k +: 8] = ref_mem[ba[11:0]];
                end
            end
            if (!wr) begin
                r = '0; r.stall = 1'b1;
                recs.push_back(r);
            end
            r = '0; r.rv = 1'b1; r.chk_rd = 1'b1;
            r.rd = wr ? m_rdata : extend(w, raw);
            recs.push_back(r);
            m_rdata = r.rd;
        end
        if (abort >= 0) begin
            while (recs.size() > abort) void'(recs.pop_back());
            r = '0; r.chk_rd = 1'b1; r.rd = 32'd0;
            recs.push_back(r);
            m_rdata = 32'd0;
        end
        for (int i = 0; i < recs.size(); i++) exp_q.push_back(recs[i]);
        for (int i = 1; i < recs.size(); i++) begin
            @(posedge clk); #1;
            if (i == 1) bus.req_valid = hold;
            if (i == abort) begin
                rst = 1'b1;
                bus.req_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.data_width = 3'd0;
        bus.addr       = 32'd0;
        bus.wdata      = 32'd0;
        for (int i = 0; i < 4096; i++) begin
            env_mem[i] <= 8'h00;
            ref_mem[i]  = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset stall",       {31'd0, bus.stall},       32'd0);
        check("reset rdata",       bus.rdata,                32'd0);
        check("reset rdata_valid", {31'd0, bus.rdata_valid}, 32'd0);
        check("reset misaligned",  {31'd0, bus.misaligned},  32'd0);
        check("reset mem_en",      {31'd0, mem_en},          32'd0);
        check("reset mem_we",      {31'd0, mem_we},          32'd0);
        check("reset mem_addr",    mem_addr,                 32'd0);
        check("reset mem_wdata",   {24'd0, mem_wdata},       32'd0);
        rst = 1'b0;
        started = 1'b1;

        poke(32'h0000_0040, 8'h80);
        poke(32'h0000_0202, 8'h34);  poke(32'h0000_0203, 8'h92);
        poke(32'h0000_0104, 8'h11);  poke(32'h0000_0105, 8'h22);
        poke(32'h0000_0106, 8'h33);
        poke(32'h0000_0200, 8'h55);  poke(32'h0000_0201, 8'h66);
        poke(32'h0000_0302, 8'hAA);  poke(32'h0000_0303, 8'hBB);
        poke(32'hFFFF_FFFD, 8'hA1);  poke(32'hFFFF_FFFE, 8'hB2);
        poke(32'hFFFF_FFFF, 8'hC3);  poke(32'h0000_0000, 8'hD4);
        @(posedge clk); #1;

        // word store
        stall_cnt = 0;
        issue(1'b1, c_DW_WORD, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, -1);
        check("sw stall cycles", 32'(stall_cnt), 32'd5);
        check("sw bytes", {env_mem[12'h103], env_mem[12'h102], env_mem[12'h101], env_mem[12'h100]},
              32'hDEAD_BEEF);

        // byte loads signed / unsigned
        issue(1'b0, c_DW_BYTE_S, 32'h0000_0040, 32'h0102_0304, 1'b0, -1);
        check("lb signed", bus.rdata, 32'hFFFF_FF80);
        issue(1'b0, c_DW_BYTE_U, 32'h0000_0040, 32'h0, 1'b0, -1);
        check("lb unsigned", bus.rdata, 32'h0000_0080);

        // half loads
        stall_cnt = 0;
        issue(1'b0, c_DW_HALF_S, 32'h0000_0202, 32'hCAFE_F00D, 1'b0, -1);
        check("lh signed", bus.rdata, 32'hFFFF_9234);
        check("lh stall cycles", 32'(stall_cnt), 32'd4);
        issue(1'b0, c_DW_HALF_U, 32'h0000_0202, 32'h0, 1'b0, -1);
        check("lh unsigned", bus.rdata, 32'h0000_9234);

        // misaligned word load
        en_cnt = 0;
        issue(1'b0, c_DW_WORD, 32'h0000_0103, 32'h0, 1'b0, -1);
`ifdef MEM_SEQ_ALIGN_CHECK_EN
        check("lw misaligned rdata", bus.rdata, 32'h0000_9234);
        check("lw misaligned beats", 32'(en_cnt), 32'd0);
`else
        check("lw unaligned rdata", bus.rdata, 32'h3322_11DE);
        check("lw unaligned beats", 32'(en_cnt), 32'd4);
`endif

        // byte store then read back
        issue(1'b1, c_DW_BYTE_U, 32'h0000_0107, 32'h0000_005A, 1'b0, -1);
        issue(1'b0, c_DW_BYTE_U, 32'h0000_0107, 32'h0, 1'b0, -1);
        check("sb readback", bus.rdata, 32'h0000_005A);

        // reset during beat 2 of a word store
        issue(1'b1, c_DW_WORD, 32'h0000_0300, 32'h1234_5678, 1'b0, 3);
        check("abort bytes", {env_mem[12'h303], env_mem[12'h302], env_mem[12'h301], env_mem[12'h300]},
              32'hBBAA_5678);
        check("abort rdata", bus.rdata, 32'd0);
        issue(1'b0, c_DW_BYTE_S, 32'h0000_0302, 32'h0, 1'b0, -1);
        check("post-reset lb", bus.rdata, 32'hFFFF_FFAA);

        // back-to-back word loads with req_valid held, second wraps
        issue(1'b0, c_DW_WORD, 32'h0000_0200, 32'h1111_1111, 1'b1, -1);
        issue(1'b0, c_DW_WORD, 32'hFFFF_FFFD, 32'h2222_2222, 1'b1, -1);
`ifdef MEM_SEQ_ALIGN_CHECK_EN
        check("b2b second rdata", bus.rdata, 32'h9234_6655);
`else
        check("b2b wrap rdata", bus.rdata, 32'hD4C3_B2A1);
`endif

        // unlisted width code behaves as word
        issue(1'b0, 3'b011, 32'h0000_0200, 32'h0, 1'b0, -1);
        check("code 011 as word", bus.rdata, 32'h9234_6655);

        repeat (3) @(posedge clk);
        #1;
        check("expect queue drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
